button_pulse: RTL and testbench

BUTTON_PULSE -- requirements
Module: button_pulse

---
 rtl/button_pulse.sv | 193 +++++++++++++++++++
 tb/tb_button_pulse.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/button_pulse.sv
// button_pulse: two-flop synchronizer, debounce FSM and optional
// auto-repeat for a mechanical push button. Produces a registered press/repeat
// strobe, a release strobe and the debounced level.
module button_pulse #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter bit REPEAT_EN       = 1'b1,
  parameter int REPEAT_DELAY    = 64,
  parameter int REPEAT_PERIOD   = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_in,
  output logic pulse,
  output logic rel_pulse,
  output logic level
);

  // Debounce counter only ever reaches DEBOUNCE_CYCLES-1; repeat counter only
  // reaches the larger of the two repeat intervals minus one. One spare bit
  // keeps both clear of any wrap.
  localparam int DW   = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW   = $clog2(RMAX) + 1;

  localparam logic [DW-1:0] DLAST   = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [RW-1:0] RDLAST  = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] RPLAST  = RW'(REPEAT_PERIOD - 1);
  localparam logic [DW-1:0] DONE    = DW'(1);
  localparam logic [RW-1:0] RONE    = RW'(1);

  // Illegal parameter values are caught at elaboration.
  if (DEBOUNCE_CYCLES < 2) begin : g_chk_db
    $error("button_pulse: DEBOUNCE_CYCLES must be >= 2");
  end
  if (REPEAT_DELAY < 2) begin : g_chk_rd
    $error("button_pulse: REPEAT_DELAY must be >= 2");
  end
  if (REPEAT_PERIOD < 1) begin : g_chk_rp
    $error("button_pulse: REPEAT_PERIOD must be >= 1");
  end

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_PRESS_CHK = 2'd1,
    S_HELD      = 2'd2,
    S_REL_CHK   = 2'd3
  } state_e;

  typedef enum logic {
    PH_DELAY  = 1'b0,
    PH_PERIOD = 1'b1
  } phase_e;

  state_e          state_q, state_d;
  phase_e          phase_q, phase_d;
  logic [DW-1:0]   dcnt_q, dcnt_d;
  logic [RW-1:0]   rcnt_q, rcnt_d;
  logic            sync1_q, btn_s;
  logic            pulse_q, pulse_d;
  logic            rel_q, rel_d;
  logic            level_q, level_d;

  // Two-flop synchronizer: the only place btn_in is sampled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b0;
      btn_s   <= 1'b0;
    end else begin
      sync1_q <= btn_in;
      btn_s   <= sync1_q;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic: a level change is accepted only after DEBOUNCE_CYCLES
  // consecutive samples agree; any disagreement aborts the check.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (btn_s) state_d = S_PRESS_CHK;
      end
      S_PRESS_CHK: begin
        if (!btn_s)               state_d = S_IDLE;
        else if (dcnt_q == DLAST) state_d = S_HELD;
      end
      S_HELD: begin
        if (!btn_s) state_d = S_REL_CHK;
      end
      S_REL_CHK: begin
        if (btn_s)                state_d = S_HELD;
        else if (dcnt_q == DLAST) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output / datapath logic: counter updates and the strobes that will be
  // registered on this edge.
  always_comb begin
    dcnt_d  = dcnt_q;
    rcnt_d  = rcnt_q;
    phase_d = phase_q;
    pulse_d = 1'b0;
    rel_d   = 1'b0;
    level_d = (state_d == S_HELD) || (state_d == S_REL_CHK);
    case (state_q)
      S_IDLE: begin
        dcnt_d = '0;
      end
      S_PRESS_CHK: begin
        if (!btn_s) begin
          dcnt_d = '0;
        end else if (dcnt_q == DLAST) begin
          // Press accepted: strobe once and restart the repeat schedule.
          pulse_d = 1'b1;
          dcnt_d  = '0;
          rcnt_d  = '0;
          phase_d = PH_DELAY;
        end else begin
          dcnt_d = dcnt_q + DONE;
        end
      end
      S_HELD: begin
        if (!btn_s) begin
          dcnt_d = '0;
        end else if (REPEAT_EN) begin
          // Only held cycles with the button still seen high advance the
          // repeat schedule.
          if (phase_q == PH_DELAY) begin
            if (rcnt_q == RDLAST) begin
              pulse_d = 1'b1;
              rcnt_d  = '0;
              phase_d = PH_PERIOD;
            end else begin
              rcnt_d = rcnt_q + RONE;
            end
          end else begin
            if (rcnt_q == RPLAST) begin
              pulse_d = 1'b1;
              rcnt_d  = '0;
            end else begin
              rcnt_d = rcnt_q + RONE;
            end
          end
        end
      end
      S_REL_CHK: begin
        // rcnt/phase are frozen here so a short glitch only pauses the cadence.
        if (btn_s) begin
          dcnt_d = '0;
        end else if (dcnt_q == DLAST) begin
          rel_d  = 1'b1;
          dcnt_d = '0;
        end else begin
          dcnt_d = dcnt_q + DONE;
        end
      end
      default: begin
        dcnt_d = '0;
      end
    endcase
  end

  // Counters, phase and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dcnt_q  <= '0;
      rcnt_q  <= '0;
      phase_q <= PH_DELAY;
      pulse_q <= 1'b0;
      rel_q   <= 1'b0;
      level_q <= 1'b0;
    end else begin
      dcnt_q  <= dcnt_d;
      rcnt_q  <= rcnt_d;
      phase_q <= phase_d;
      pulse_q <= pulse_d;
      rel_q   <= rel_d;
      level_q <= level_d;
    end
  end

  assign pulse     = pulse_q;
  assign rel_pulse = rel_q;
  assign level     = level_q;

endmodule

// File: tb/tb_button_pulse.sv
// Scoreboard bench for button_pulse. Stimulus pushes each expected strobe
// (kind + cycle number) into a per-DUT queue; the monitor pops and compares
// whenever a DUT raises pulse or rel_pulse. Cycle numbers count rising edges;
// a strobe registered on edge N is observed at the following falling edge
// with cyc == N.
module tb_button_pulse;
  localparam int D  = 4;
  localparam int RD = 8;
  localparam int RP = 3;

  logic clk = 1'b0;
  logic rst_a, rst_b, btn_a, btn_b;
  logic pulse_a, rel_a, level_a;
  logic pulse_b, rel_b, level_b;

  int cyc = 0;
  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    bit rel;
    int at;
  } ev_t;

  ev_t q_a[$];
  ev_t q_b[$];
  ev_t e_m;
  bit  have_m;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  button_pulse #(.DEBOUNCE_CYCLES(D), .REPEAT_EN(1'b1), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP))
    u_dut_a (.clk(clk), .rst(rst_a), .btn_in(btn_a), .pulse(pulse_a), .rel_pulse(rel_a), .level(level_a));

  button_pulse #(.DEBOUNCE_CYCLES(D), .REPEAT_EN(1'b0), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP))
    u_dut_b (.clk(clk), .rst(rst_b), .btn_in(btn_b), .pulse(pulse_b), .rel_pulse(rel_b), .level(level_b));

  task automatic judge(input string nm, input bit have, input ev_t e, input bit is_rel);
    n_cmp++;
    if (!have) begin
      n_err++;
      $display("FAIL %s: got %s at cycle %0d, required no strobe", nm,
               is_rel ? "rel_pulse" : "pulse", cyc);
    end else if (e.rel != is_rel || e.at != cyc) begin
      n_err++;
      $display("FAIL %s: got %s at cycle %0d, required %s at cycle %0d", nm,
               is_rel ? "rel_pulse" : "pulse", cyc, e.rel ? "rel_pulse" : "pulse", e.at);
    end
  endtask

  // Monitor: one scoreboard pop per observed strobe.
  always @(negedge clk) begin
    if (pulse_a || rel_a) begin
      if (pulse_a && rel_a) begin
        n_cmp++; n_err++;
        $display("FAIL dut_a_overlap: pulse and rel_pulse both 1 at cycle %0d, required exclusive", cyc);
      end
      have_m = (q_a.size() > 0);
      if (have_m) e_m = q_a.pop_front();
      judge("dut_a_strobe", have_m, e_m, rel_a);
    end
    if (pulse_b || rel_b) begin
      if (pulse_b && rel_b) begin
        n_cmp++; n_err++;
        $display("FAIL dut_b_overlap: pulse and rel_pulse both 1 at cycle %0d, required exclusive", cyc);
      end
      have_m = (q_b.size() > 0);
      if (have_m) e_m = q_b.pop_front();
      judge("dut_b_strobe", have_m, e_m, rel_b);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string nm, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b, required %b (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic push_a(input bit rel, input int at);
    q_a.push_back(ev_t'{rel: rel, at: at});
  endtask

  task automatic push_b(input bit rel, input int at);
    q_b.push_back(ev_t'{rel: rel, at: at});
  endtask

  int c, r;

  initial begin
    rst_a = 1'b1; rst_b = 1'b1; btn_a = 1'b0; btn_b = 1'b0;
    tick(2);
    chk("rst_pulse_a", pulse_a, 1'b0);
    chk("rst_rel_a",   rel_a,   1'b0);
    chk("rst_level_a", level_a, 1'b0);
    chk("rst_pulse_b", pulse_b, 1'b0);
    chk("rst_rel_b",   rel_b,   1'b0);
    chk("rst_level_b", level_b, 1'b0);
    rst_a = 1'b0; rst_b = 1'b0;
    tick(3);

    // Clean press, 5 cycles high: press strobe 7 edges in, release 7 edges
    // after the fall.
    c = cyc; btn_a = 1'b1;
    push_a(1'b0, c + 7); push_a(1'b1, c + 12);
    tick(5); btn_a = 1'b0;
    tick(2); chk("clean_level_hi", level_a, 1'b1);
    tick(4); chk("clean_level_hold", level_a, 1'b1);
    tick(1); chk("clean_level_lo", level_a, 1'b0);
    tick(5);

    // Bounce 1,0,1,0: nothing may come out.
    btn_a = 1'b1; tick(1); btn_a = 1'b0; tick(1);
    btn_a = 1'b1; tick(1); btn_a = 1'b0;
    tick(3); chk("bounce_level", level_a, 1'b0);
    tick(10); chk("bounce_level_end", level_a, 1'b0);

    // Held 30 cycles: press at c+7, repeats at c+15 then every 3 cycles
    // while the held state still sees the button high (last counted edge c+32).
    c = cyc; btn_a = 1'b1;
    push_a(1'b0, c + 7);
    for (int j = 0; j < 6; j++) push_a(1'b0, c + 15 + 3 * j);
    push_a(1'b1, c + 37);
    tick(30); btn_a = 1'b0;
    tick(10); chk("repeat_level_lo", level_a, 1'b0);
    tick(3);

    // Glitch low for 2 cycles while held. Three edges do not advance the
    // repeat counter (held-with-low, one release-check step, the return), so
    // the first repeat moves from c+15 to c+18.
    c = cyc; btn_a = 1'b1;
    push_a(1'b0, c + 7); push_a(1'b0, c + 18); push_a(1'b0, c + 21);
    push_a(1'b1, c + 27);
    tick(9); btn_a = 1'b0; tick(2); btn_a = 1'b1;
    tick(2); chk("glitch_level", level_a, 1'b1);
    tick(7); btn_a = 1'b0;
    tick(10);

    // Reset during the press strobe with the button kept high: outputs clear
    // at once, then a fresh full debounce.
    c = cyc; btn_a = 1'b1;
    push_a(1'b0, c + 7);
    tick(7);
    #1 rst_a = 1'b1;
    #1 chk("rstmid_pulse", pulse_a, 1'b0);
    chk("rstmid_level", level_a, 1'b0);
    tick(2);
    r = cyc; rst_a = 1'b0;
    push_a(1'b0, r + 7);
    tick(8); chk("rstmid_level_hi", level_a, 1'b1);
    btn_a = 1'b0; push_a(1'b1, r + 15);
    tick(10);

    // Reset mid-debounce: no pending press may escape afterwards.
    btn_a = 1'b1; tick(4);
    rst_a = 1'b1; btn_a = 1'b0;
    #1 chk("rstdb_level", level_a, 1'b0);
    tick(2); rst_a = 1'b0;
    tick(12); chk("rstdb_level_end", level_a, 1'b0);

    // Repeat disabled, held 40 cycles: one press and one release only.
    c = cyc; btn_b = 1'b1;
    push_b(1'b0, c + 7); push_b(1'b1, c + 47);
    tick(20); chk("norep_level", level_b, 1'b1);
    tick(20); btn_b = 1'b0;
    tick(12); chk("norep_level_lo", level_b, 1'b0);

    n_cmp++;
    if (q_a.size() != 0) begin
      n_err++;
      $display("FAIL dut_a_missing: %0d strobes never seen, required 0", q_a.size());
    end
    n_cmp++;
    if (q_b.size() != 0) begin
      n_err++;
      $display("FAIL dut_b_missing: %0d strobes never seen, required 0", q_b.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
